// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 (optionally 8E1) UART receiver.
//
// Oversamples the asynchronous serial line with the system clock, confirms the
// start bit at its midpoint, samples every following bit at its midpoint and
// reassembles LSB-first data words. Each good word is held on dataOut until the
// next good frame, with dataValid high until the consumer reads it.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> an even-parity bit follows the data bits; parityErr pulses on
//                mismatch and the word is discarded.
//   undefined -> plain 8N1 framing, parityErr tied low.
//
// Parameters:
//   DATA_WIDTH      data bits per frame
//   CLOCKS_PER_BIT  clk cycles per serial bit (minimum 4)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   uartBus    asynchronous serial line, idle high
//   rdEn       consumer read strobe; clears dataValid and overrun
//   dataOut    last received word
//   dataValid  high while dataOut holds an unread word
//   frameErr   one-cycle pulse when the stop bit is sampled low
//   overrun    sticky; a new word landed on top of an unread one
//   parityErr  one-cycle pulse on parity mismatch
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int DATA_WIDTH     = 8,
   parameter int CLOCKS_PER_BIT = 10417
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  uartBus,
   input  logic                  rdEn,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   output logic                  frameErr,
   output logic                  overrun,
   output logic                  parityErr
);

   localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
   localparam int HALF  = CLOCKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BREAK
   } state_t;

   state_t                  state, nextState;
   logic                    rxMeta, rxS;
   logic [CNT_W-1:0]        count;
   logic [IDX_W-1:0]        bitIdx;
   logic [DATA_WIDTH-1:0]   shiftReg;

   // Control strobes from the output decode.
   logic tick;          // count at the sample point for the current state
   logic countRun;
   logic shiftEn;
   logic parSample;
   logic wordReady;
   logic frameErrSet;
   logic parityErrSet;
   logic parityOk;

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values;
      // blocking here would collapse the two stages into one.
      if (!rst) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= uartBus;
         rxS    <= rxMeta;
      end
   end

   // The start bit is confirmed half a bit in; every later sample is a full bit
   // after the previous one, which keeps all samples at mid-bit.
   assign tick = (state == START) ? (count == HALF_LAST) : (count == BIT_LAST);

`ifdef UART_RX_PARITY_EN
   logic parityBit;
   assign parityOk = ~(^shiftReg ^ parityBit);
`else
   assign parityOk = 1'b1;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves the signal
      // unassigned, which would infer a latch.
      nextState = state;
      case (state)
         IDLE:   if (!rxS) nextState = START;
         START:  if (tick) nextState = rxS ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:   if (tick && bitIdx == IDX_LAST) nextState = PARITY;
         PARITY: if (tick) nextState = STOP;
`else
         DATA:   if (tick && bitIdx == IDX_LAST) nextState = STOP;
`endif
         // Leaving STOP at the stop-bit midpoint lets a back-to-back start bit
         // be seen; a low stop bit parks in BREAK until the line recovers.
         STOP:   if (tick) nextState = rxS ? IDLE : BREAK;
         BREAK:  if (rxS) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // FSM output decode.
   always_comb begin
      countRun     = state inside {START, DATA, PARITY, STOP};
      shiftEn      = 1'b0;
      parSample    = 1'b0;
      wordReady    = 1'b0;
      frameErrSet  = 1'b0;
      parityErrSet = 1'b0;
      case (state)
         DATA:    shiftEn   = tick;
         PARITY:  parSample = tick;
         STOP: begin
            if (tick) begin
               if (!rxS)          frameErrSet  = 1'b1;
               else if (parityOk) wordReady    = 1'b1;
               else               parityErrSet = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Bit timing and data assembly.
   always_ff @(posedge clk) begin
      // NOTE: the data-path registers are reset too, because dataOut must
      // read zero out of reset and reset must abort any frame in flight.
      if (!rst) begin
         count    <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         if (!countRun || tick) count <= '0;
         else                   count <= count + CNT_W'(1);

         if (state == START && tick) bitIdx <= '0;
         else if (shiftEn)           bitIdx <= bitIdx + IDX_W'(1);

         if (shiftEn) shiftReg <= {rxS, shiftReg[DATA_WIDTH-1:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         parityBit <= 1'b0;
         parityErr <= 1'b0;
      end else begin
         if (parSample) parityBit <= rxS;
         parityErr <= parityErrSet;
      end
   end
`else
   assign parityErr = 1'b0;
`endif

   // Hold-until-read output interface.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dataOut   <= '0;
         dataValid <= 1'b0;
         frameErr  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frameErr <= frameErrSet;
         if (wordReady) begin
            dataOut   <= shiftReg;
            dataValid <= 1'b1;
            // A read in the same cycle consumes the old word, so no overrun.
            if (dataValid && !rdEn)     overrun <= 1'b1;
            else if (dataValid && rdEn) overrun <= 1'b0;
         end else if (rdEn && dataValid) begin
            dataValid <= 1'b0;
            overrun   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
//
// Runs with CLOCKS_PER_BIT=16, DATA_WIDTH=8. Serial frames are driven on the
// falling clock edge, and outputs are checked on the falling edge as well.
// frameErr / parityErr pulses are counted by a monitor so that pulse count and
// pulse width can both be checked. Honours UART_RX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int DW  = 8;

`ifdef UART_RX_PARITY_EN
   localparam int EXP_PE_TOTAL = 1;
`else
   localparam int EXP_PE_TOTAL = 0;
`endif

   logic          clk     = 1'b0;
   logic          rst     = 1'b0;
   logic          uartBus = 1'b1;
   logic          rdEn    = 1'b0;
   logic [DW-1:0] dataOut;
   logic          dataValid;
   logic          frameErr;
   logic          overrun;
   logic          parityErr;

   int nCompared   = 0;
   int nMismatched = 0;
   int feCnt       = 0;
   int peCnt       = 0;
   int feBase;

`ifdef UART_RX_PARITY_EN
   logic parFlip = 1'b0;
   int   peBase;
`endif

   always #5 clk = ~clk;

   uart_rx #(
      .DATA_WIDTH    (DW),
      .CLOCKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .uartBus  (uartBus),
      .rdEn     (rdEn),
      .dataOut  (dataOut),
      .dataValid(dataValid),
      .frameErr (frameErr),
      .overrun  (overrun),
      .parityErr(parityErr)
   );

   // Counts cycles each error flag is high; a single one-cycle pulse adds 1.
   always @(negedge clk) begin
      if (rst) begin
         feCnt <= feCnt + int'(frameErr);
         peCnt <= peCnt + int'(parityErr);
      end
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      uartBus = b;
      waitCycles(CPB);
   endtask

   // One full frame. rdAtStop raises rdEn for exactly the cycle in which the
   // receiver samples the stop bit (the 11th cycle of the stop bit, counted
   // from the start-bit edge through the 2-flop synchronizer).
   task automatic sendFrame(input logic [DW-1:0] d, input logic stopBit,
                            input logic rdAtStop);
      sendBit(1'b0);
      for (int i = 0; i < DW; i++) sendBit(d[i]);
`ifdef UART_RX_PARITY_EN
      sendBit(^d ^ parFlip);
`endif
      uartBus = stopBit;
      waitCycles(10);
      rdEn = rdAtStop;
      waitCycles(1);
      rdEn = 1'b0;
      waitCycles(CPB - 11);
   endtask

   task automatic pulseRead();
      rdEn = 1'b1;
      waitCycles(1);
      rdEn = 1'b0;
   endtask

   initial begin
      // Reset with the line idle.
      rst     = 1'b0;
      uartBus = 1'b1;
      waitCycles(3);
      check("reset_dataOut",   32'(dataOut),   32'h00);
      check("reset_dataValid", 32'(dataValid), 32'h0);
      check("reset_frameErr",  32'(frameErr),  32'h0);
      check("reset_overrun",   32'(overrun),   32'h0);
      check("reset_parityErr", 32'(parityErr), 32'h0);
      rst = 1'b1;
      waitCycles(2);

      // Basic frame 0xA5, then read it.
      sendFrame(8'hA5, 1'b1, 1'b0);
      check("a5_dataOut",   32'(dataOut),   32'hA5);
      check("a5_dataValid", 32'(dataValid), 32'h1);
      check("a5_overrun",   32'(overrun),   32'h0);
      pulseRead();
      check("a5_read_dataValid", 32'(dataValid), 32'h0);
      check("a5_read_dataOut",   32'(dataOut),   32'hA5);

      // 4-cycle glitch is rejected at the start-bit midpoint.
      feBase  = feCnt;
      uartBus = 1'b0;
      waitCycles(4);
      uartBus = 1'b1;
      waitCycles(40);
      check("glitch_dataValid", 32'(dataValid),     32'h0);
      check("glitch_frameErr",  32'(feCnt - feBase), 32'h0);
      check("glitch_dataOut",   32'(dataOut),       32'hA5);

      // 0x3C with a low stop bit, line then held low: one frameErr pulse, word
      // dropped, and no new frame until the line returns high.
      feBase = feCnt;
      sendFrame(8'h3C, 1'b0, 1'b0);
      uartBus = 1'b0;
      waitCycles(40);
      check("ferr_pulse_during_low", 32'(feCnt - feBase), 32'h1);
      uartBus = 1'b1;
      waitCycles(200);
      check("ferr_pulse_total", 32'(feCnt - feBase), 32'h1);
      check("ferr_dataValid",   32'(dataValid),     32'h0);
      check("ferr_dataOut",     32'(dataOut),       32'hA5);

      // Back-to-back 0x11, 0x22 without a read: overrun.
      sendFrame(8'h11, 1'b1, 1'b0);
      check("b2b_first_dataOut", 32'(dataOut), 32'h11);
      check("b2b_first_overrun", 32'(overrun), 32'h0);
      sendFrame(8'h22, 1'b1, 1'b0);
      check("b2b_dataOut",   32'(dataOut),   32'h22);
      check("b2b_dataValid", 32'(dataValid), 32'h1);
      check("b2b_overrun",   32'(overrun),   32'h1);
      pulseRead();
      check("b2b_read_dataValid", 32'(dataValid), 32'h0);
      check("b2b_read_overrun",   32'(overrun),   32'h0);

      // New word arriving in the same cycle as a read: no overrun.
      sendFrame(8'h44, 1'b1, 1'b0);
      check("same_first_dataValid", 32'(dataValid), 32'h1);
      sendFrame(8'h33, 1'b1, 1'b1);
      check("same_dataOut",   32'(dataOut),   32'h33);
      check("same_dataValid", 32'(dataValid), 32'h1);
      check("same_overrun",   32'(overrun),   32'h0);
      pulseRead();
      check("same_read_dataValid", 32'(dataValid), 32'h0);
      // A read with nothing pending changes nothing.
      pulseRead();
      check("idle_read_dataValid", 32'(dataValid), 32'h0);
      check("idle_read_dataOut",   32'(dataOut),   32'h33);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones, so even parity needs a 1; send 0 first.
      peBase  = peCnt;
      parFlip = 1'b1;
      sendFrame(8'h07, 1'b1, 1'b0);
      parFlip = 1'b0;
      check("par_bad_pulse",     32'(peCnt - peBase), 32'h1);
      check("par_bad_dataValid", 32'(dataValid),     32'h0);
      sendFrame(8'h07, 1'b1, 1'b0);
      check("par_good_dataOut",   32'(dataOut),       32'h07);
      check("par_good_dataValid", 32'(dataValid),     32'h1);
      check("par_good_pulse",     32'(peCnt - peBase), 32'h1);
      pulseRead();
`endif

      // Reset in the middle of a frame aborts it and clears the outputs.
      sendFrame(8'h5A, 1'b1, 1'b0);
      check("pre_rst_dataOut",   32'(dataOut),   32'h5A);
      check("pre_rst_dataValid", 32'(dataValid), 32'h1);
      uartBus = 1'b0;
      waitCycles(3 * CPB);
      rst = 1'b0;
      waitCycles(2);
      check("midrst_dataOut",   32'(dataOut),   32'h00);
      check("midrst_dataValid", 32'(dataValid), 32'h0);
      rst     = 1'b1;
      uartBus = 1'b1;
      waitCycles(200);
      check("post_rst_dataValid", 32'(dataValid), 32'h0);
      sendFrame(8'hC3, 1'b1, 1'b0);
      check("post_rst_dataOut",   32'(dataOut),   32'hC3);
      check("post_rst_dataValid", 32'(dataValid), 32'h1);

      check("parityErr_total", 32'(peCnt), 32'(EXP_PE_TOTAL));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCompared, nMismatched);
      $finish;
   end

endmodule
